otter_pc_fetch: RTL and testbench
=================================

// Module: otter_pc_fetch
//
// PURPOSE
//  Program-counter register and instruction-fetch stage of the OTTER core.
//  - Consumes the 32-bit next-PC selected by the PC-source mux.
//  - Holds the architectural PC and drives the instruction-memory read handshake.
//  - Latches the fetched instruction into IR for the decoder/control FSM.
//  - Supplies PC and PC+4 back to the PC-source mux and the datapath.
//
// PARAMETERS
//  RESET_VEC  32'h0000_0000  PC value loaded on reset; bits [1:0] must be 0 (elaboration-time check)
//
// PORTS
//  CLK         in   1   system clock, all state updates on rising edge
//  RST         in   1   asynchronous reset, active-high
//  NEXT_PC     in   32  next PC from the PC-source mux
//  PC_WRITE    in   1   control FSM request to advance PC to NEXT_PC
//  IMEM_REQ    out  1   instruction read request, one-cycle pulse
//  IMEM_ADDR   out  32  instruction read address (= PC)
//  IMEM_RVALID in   1   read data valid from instruction memory
//  IMEM_RDATA  in   32  instruction word
//  PC          out  32  current program counter
//  PC_4        out  32  PC + 4, to PC-source mux input 0
//  IR          out  32  latched instruction
//  IR_VALID    out  1   IR holds the instruction at PC
//  MISALIGN    out  1   one-cycle pulse: PC_WRITE rejected, NEXT_PC[1:0] != 0
//  INSTRET     out  32  count of accepted PC_WRITEs
//
// BEHAVIOUR
//  Reset (async, any state):
//  - PC = RESET_VEC, IR = 0, IR_VALID = 0, MISALIGN = 0, INSTRET = 0, state = FETCH.
//
//  Combinational outputs:
//  - IMEM_ADDR = PC.
//  - PC_4 = PC + 4, modulo 2^32 (0xFFFF_FFFC -> 0x0000_0000).
//  - IMEM_REQ = (state == FETCH).
//
//  FSM:
//  - FETCH: IMEM_REQ = 1 for exactly one cycle; next state WAIT.
//  - WAIT:  IMEM_REQ = 0. Stays in WAIT until IMEM_RVALID = 1 (no timeout, any number of wait cycles).
//    On RVALID: IR <= IMEM_RDATA, IR_VALID <= 1, next state HOLD.
//  - HOLD:  IR and IR_VALID are stable; waits for PC_WRITE.
//    PC_WRITE = 1 with NEXT_PC[1:0] == 0:
//    - PC <= NEXT_PC, IR_VALID <= 0, INSTRET <= INSTRET + 1 (wraps), next state FETCH.
//    PC_WRITE = 1 with NEXT_PC[1:0] != 0:
//    - PC unchanged, IR/IR_VALID unchanged, MISALIGN = 1 for the next cycle only, remain in HOLD.
//    - The control FSM then selects MTVEC.
//
//  Boundary rules:
//  - PC_WRITE in FETCH or WAIT is ignored; no state, PC or counter change.
//  - IMEM_RVALID in FETCH or HOLD is ignored; covers stale responses after reset or redirect.
//  - NEXT_PC == PC is legal: the instruction is re-fetched, INSTRET increments.
//  - Minimum instruction period: 3 cycles (FETCH, WAIT with RVALID, HOLD with PC_WRITE).
//
// TESTING
//  1. Reset release with RESET_VEC = 0 -> first cycle IMEM_REQ = 1, IMEM_ADDR = 0, IR_VALID = 0, PC_4 = 4.
//  2. RVALID 1 cycle after REQ, RDATA = 0x0000_0013 -> IR = 0x13, IR_VALID = 1; repeat with 3 wait cycles, same result.
//  3. HOLD + PC_WRITE, NEXT_PC = 0x100 -> PC = 0x100, IR_VALID = 0, INSTRET = 1, next REQ with ADDR = 0x100.
//  4. HOLD + PC_WRITE, NEXT_PC = 0x102 -> MISALIGN high 1 cycle, PC/IR/INSTRET unchanged, still HOLD.
//  5. PC = 0xFFFF_FFFC -> PC_4 = 0; PC_WRITE asserted during WAIT is ignored.
//  6. RST asserted mid-WAIT, RVALID pulsed in the first post-reset cycle -> PC = RESET_VEC, IR = 0, IR_VALID = 0, response ignored.

Source files
------------

// File: rtl/otter_pc_fetch.sv
// PC register plus instruction fetch: FETCH issues a one-cycle IMEM_REQ, WAIT holds until IMEM_RVALID, HOLD keeps IR until PC_WRITE.
// Latency: at least 3 cycles per instruction. IMEM_RVALID is ignored outside WAIT and PC_WRITE outside HOLD; a misaligned NEXT_PC is refused.
module otter_pc_fetch #(
    parameter logic [31:0] RESET_VEC = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [31:0] NEXT_PC,
    input  logic        PC_WRITE,
    output logic        IMEM_REQ,
    output logic [31:0] IMEM_ADDR,
    input  logic        IMEM_RVALID,
    input  logic [31:0] IMEM_RDATA,
    output logic [31:0] PC,
    output logic [31:0] PC_4,
    output logic [31:0] IR,
    output logic        IR_VALID,
    output logic        MISALIGN,
    output logic [31:0] INSTRET
);

    generate
        if (RESET_VEC[1:0] != 2'b00) begin : g_bad_reset_vec
            $error("otter_pc_fetch: RESET_VEC must be word aligned");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_WAIT  = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    state_t      state;
    logic [31:0] pc_q;
    logic [31:0] ir_q;
    logic        ir_vld_q;
    logic        misalign_q;
    logic [31:0] instret_q;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state      <= ST_FETCH;
            pc_q       <= RESET_VEC;
            ir_q       <= 32'h0;
            ir_vld_q   <= 1'b0;
            misalign_q <= 1'b0;
            instret_q  <= 32'h0;
        end else begin
            misalign_q <= 1'b0;
            case (state)
                ST_FETCH: state <= ST_WAIT;
                ST_WAIT: begin
                    if (IMEM_RVALID) begin
                        ir_q     <= IMEM_RDATA;
                        ir_vld_q <= 1'b1;
                        state    <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (PC_WRITE) begin
                        // A misaligned target is refused so the control FSM can trap to MTVEC.
                        if (NEXT_PC[1:0] == 2'b00) begin
                            pc_q      <= NEXT_PC;
                            ir_vld_q  <= 1'b0;
                            instret_q <= instret_q + 32'd1;
                            state     <= ST_FETCH;
                        end else begin
                            misalign_q <= 1'b1;
                        end
                    end
                end
                default: state <= ST_FETCH;
            endcase
        end
    end

    assign IMEM_REQ  = (state == ST_FETCH);
    assign IMEM_ADDR = pc_q;
    assign PC        = pc_q;
    assign PC_4      = pc_q + 32'd4;
    assign IR        = ir_q;
    assign IR_VALID  = ir_vld_q;
    assign MISALIGN  = misalign_q;
    assign INSTRET   = instret_q;

endmodule

// File: tb/tb_otter_pc_fetch.sv
// Transaction-level bench for otter_pc_fetch: directed scenarios then randomized fetch/redirect traffic.
module tb_otter_pc_fetch;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [31:0] NEXT_PC = 32'h0;
    logic        PC_WRITE = 1'b0;
    logic        IMEM_REQ;
    logic [31:0] IMEM_ADDR;
    logic        IMEM_RVALID = 1'b0;
    logic [31:0] IMEM_RDATA = 32'h0;
    logic [31:0] PC;
    logic [31:0] PC_4;
    logic [31:0] IR;
    logic        IR_VALID;
    logic        MISALIGN;
    logic [31:0] INSTRET;

    otter_pc_fetch #(.RESET_VEC(32'h0000_0000)) dut (
        .CLK(CLK), .RST(RST), .NEXT_PC(NEXT_PC), .PC_WRITE(PC_WRITE),
        .IMEM_REQ(IMEM_REQ), .IMEM_ADDR(IMEM_ADDR),
        .IMEM_RVALID(IMEM_RVALID), .IMEM_RDATA(IMEM_RDATA),
        .PC(PC), .PC_4(PC_4), .IR(IR), .IR_VALID(IR_VALID),
        .MISALIGN(MISALIGN), .INSTRET(INSTRET)
    );

    always #5 CLK = ~CLK;

    int passed = 0;
    int total  = 0;

    // Architectural reference: what the PC, IR and retired count should be.
    logic [31:0] m_pc      = 32'h0;
    logic [31:0] m_ir      = 32'h0;
    logic        m_irv     = 1'b0;
    logic [31:0] m_instret = 32'h0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk_arch(input string tag);
        chk({tag, ".pc"}, PC, m_pc);
        chk({tag, ".addr"}, IMEM_ADDR, m_pc);
        chk({tag, ".pc4"}, PC_4, m_pc + 32'd4);
        chk({tag, ".instret"}, INSTRET, m_instret);
        chk({tag, ".ir"}, IR, m_ir);
        chk({tag, ".irv"}, {31'h0, IR_VALID}, {31'h0, m_irv});
    endtask

    // Called while in WAIT: idle for 'waits' cycles, then deliver 'data'.
    task automatic deliver(input int waits, input logic [31:0] data, input logic stray_pw);
        for (int i = 0; i < waits; i++) begin
            IMEM_RVALID = 1'b0;
            PC_WRITE    = stray_pw;
            NEXT_PC     = $urandom & 32'hFFFF_FFFC;
            chk("wait.req", {31'h0, IMEM_REQ}, 32'h0);
            chk_arch("wait");
            tick();
        end
        IMEM_RVALID = 1'b1;
        IMEM_RDATA  = data;
        chk("wait.req", {31'h0, IMEM_REQ}, 32'h0);
        tick();
        IMEM_RVALID = 1'b0;
        PC_WRITE    = 1'b0;
        m_ir  = data;
        m_irv = 1'b1;
        chk("hold.req", {31'h0, IMEM_REQ}, 32'h0);
        chk_arch("hold");
    endtask

    // Called while in FETCH; optionally offers a stale response and a stray PC_WRITE.
    task automatic fetch(input int waits, input logic [31:0] data, input logic stray);
        chk("fetch.req", {31'h0, IMEM_REQ}, 32'h1);
        chk_arch("fetch");
        IMEM_RVALID = stray;
        IMEM_RDATA  = ~data;
        PC_WRITE    = stray;
        NEXT_PC     = 32'h0000_0400;
        tick();
        IMEM_RVALID = 1'b0;
        deliver(waits, data, stray);
    endtask

    // Called while in HOLD.
    task automatic do_write(input logic [31:0] npc);
        PC_WRITE = 1'b1;
        NEXT_PC  = npc;
        tick();
        PC_WRITE = 1'b0;
        if (npc[1:0] == 2'b00) begin
            m_pc      = npc;
            m_instret = m_instret + 32'd1;
            m_irv     = 1'b0;
            chk("wr.misalign", {31'h0, MISALIGN}, 32'h0);
            chk("wr.req", {31'h0, IMEM_REQ}, 32'h1);
            chk_arch("wr");
        end else begin
            chk("mis.pulse", {31'h0, MISALIGN}, 32'h1);
            chk("mis.req", {31'h0, IMEM_REQ}, 32'h0);
            chk_arch("mis");
            tick();
            chk("mis.clear", {31'h0, MISALIGN}, 32'h0);
            chk("mis.hold", {31'h0, IMEM_REQ}, 32'h0);
            chk_arch("mis2");
        end
    endtask

    task automatic idle_hold(input int n);
        for (int i = 0; i < n; i++) begin
            IMEM_RVALID = 1'($urandom_range(0, 1));
            IMEM_RDATA  = $urandom;
            tick();
            IMEM_RVALID = 1'b0;
            chk("idle.req", {31'h0, IMEM_REQ}, 32'h0);
            chk_arch("idle");
        end
    endtask

    initial begin
        logic [31:0] r;
        tick();
        tick();
        RST = 1'b0;
        // Reset release: first cycle is FETCH at RESET_VEC.
        chk("rst.misalign", {31'h0, MISALIGN}, 32'h0);
        fetch(0, 32'h0000_0013, 1'b0);
        do_write(32'h0000_0100);
        fetch(3, 32'h0000_0013, 1'b0);
        do_write(32'h0000_0102);
        idle_hold(2);
        do_write(32'hFFFF_FFFC);
        fetch(2, 32'h1234_5678, 1'b1);
        do_write(32'hFFFF_FFFC);
        fetch(1, 32'h0000_0093, 1'b1);
        do_write(32'h0000_0200);

        // Reset in the middle of WAIT, then a stale response right after.
        chk("pre.req", {31'h0, IMEM_REQ}, 32'h1);
        tick();
        RST = 1'b1;
        #1;
        m_pc = 32'h0; m_ir = 32'h0; m_irv = 1'b0; m_instret = 32'h0;
        chk("arst.req", {31'h0, IMEM_REQ}, 32'h1);
        chk("arst.misalign", {31'h0, MISALIGN}, 32'h0);
        chk_arch("arst");
        tick();
        RST         = 1'b0;
        IMEM_RVALID = 1'b1;
        IMEM_RDATA  = 32'hDEAD_BEEF;
        chk("post.req", {31'h0, IMEM_REQ}, 32'h1);
        tick();
        IMEM_RVALID = 1'b0;
        chk("post.req2", {31'h0, IMEM_REQ}, 32'h0);
        chk_arch("post");
        deliver(2, 32'h0000_0033, 1'b0);
        do_write(32'h0000_0000);

        for (int it = 0; it < 40; it++) begin
            fetch($urandom_range(0, 4), $urandom, 1'($urandom_range(0, 1)));
            idle_hold($urandom_range(0, 2));
            if ($urandom_range(0, 2) == 0) begin
                r = $urandom;
                r[1:0] = 2'($urandom_range(1, 3));
                do_write(r);
            end
            if ($urandom_range(0, 4) == 0) begin
                do_write(m_pc);
            end else begin
                r = $urandom;
                r[1:0] = 2'b00;
                do_write(r);
            end
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "bench timeout");
    end

endmodule
